main_memory: RTL

Main-memory responder for the cache miss interface. It accepts cacheline read requests from the icache and write-backs from the dcache, queues them in FIFO order, and serves them one at a time after a fixed latency. Each read is returned as a single-cycle `mem_rec_en` pulse carrying the line-aligned address and the full cacheline. It sits behind the cache/MMU layer and terminates the `mem_req_*` / `mem_rec_*` protocol.

---
 rtl/main_memory.sv | 137 +++++++++++++
 1 files changed

// File: rtl/main_memory.sv
// Cacheline memory responder: FIFO-ordered read/write-back requests, each served LATENCY edges after it enters the engine.
// Requests are dropped (sticky overflow) while mem_req_full is high; reads return one mem_rec_en pulse.
module main_memory #(
  parameter int LATENCY     = 5,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LINES   = 1024,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int OFFSET_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_ren,
  input  logic              mem_req_wen,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_wdata,
  output logic              mem_rec_en,
  output logic [ADDR_W-1:0] mem_rec_addr,
  output logic [LINE_W-1:0] mem_rec_cacheline,
  output logic              mem_req_full,
  output logic              overflow
);

  localparam int LA_W  = ADDR_W - OFFSET_W;
  localparam int QA_W  = $clog2(QUEUE_DEPTH);
  localparam int ML_W  = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic              q_write [QUEUE_DEPTH];
  logic [LA_W-1:0]   q_laddr [QUEUE_DEPTH];
  logic [LINE_W-1:0] q_wdata [QUEUE_DEPTH];
  logic [QA_W:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [QA_W-1:0]   wr_idx, rd_idx;

  logic [LINE_W-1:0] mem [MEM_LINES];

  logic              eng_write;
  logic [LA_W-1:0]   eng_laddr;
  logic [LINE_W-1:0] eng_wdata;
  logic [ML_W-1:0]   eng_line;

  logic              in_vld, in_accept, q_empty, eng_done, take;
  logic              pop, direct, push, load, full_nxt, serve_rd;
  logic              ent_write;
  logic [LA_W-1:0]   ent_laddr;
  logic [LINE_W-1:0] ent_wdata;
  logic              offset_unused;

  assign offset_unused = ^mem_req_addr[OFFSET_W-1:0];

  assign in_vld    = mem_req_ren | mem_req_wen;
  assign in_accept = in_vld && !mem_req_full;
  assign q_empty   = (wr_ptr == rd_ptr);
  assign wr_idx    = wr_ptr[QA_W-1:0];
  assign rd_idx    = rd_ptr[QA_W-1:0];
  assign eng_line  = eng_laddr[ML_W-1:0];

  // The engine takes a new entry when idle or on the edge it finishes the
  // current one; an empty queue lets the incoming request go straight in.
  assign eng_done = (state == BUSY) && (cnt == '0);
  assign take     = (state == IDLE) || eng_done;
  assign pop      = take && !q_empty;
  assign direct   = take && q_empty && in_accept;
  assign push     = in_accept && !direct;
  assign load     = pop || direct;
  assign serve_rd = eng_done && !eng_write;

  assign ent_write = pop ? q_write[rd_idx] : mem_req_wen;
  assign ent_laddr = pop ? q_laddr[rd_idx] : mem_req_addr[ADDR_W-1:OFFSET_W];
  assign ent_wdata = pop ? q_wdata[rd_idx] : mem_req_wdata;

  assign wr_ptr_nxt = wr_ptr + {{QA_W{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{QA_W{1'b0}}, pop};
  assign full_nxt   = (wr_ptr_nxt[QA_W] != rd_ptr_nxt[QA_W]) &&
                      (wr_ptr_nxt[QA_W-1:0] == rd_ptr_nxt[QA_W-1:0]);

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = BUSY;
    else if (eng_done)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      mem_req_full      <= 1'b0;
      overflow          <= 1'b0;
      mem_rec_en        <= 1'b0;
      mem_rec_addr      <= '0;
      mem_rec_cacheline <= '0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      mem_req_full <= full_nxt;
      if ((in_vld && mem_req_full) || (mem_req_ren && mem_req_wen))
        overflow <= 1'b1;
      if (load)
        cnt <= CNT_LOAD;
      else if ((state == BUSY) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
      mem_rec_en <= serve_rd;
      if (serve_rd) begin
        mem_rec_addr      <= {eng_laddr, {OFFSET_W{1'b0}}};
        mem_rec_cacheline <= mem[eng_line];
      end
    end
  end

  // Payload storage carries no reset; memory contents survive rst.
  always_ff @(posedge clk) begin
    if (push) begin
      q_write[wr_idx] <= mem_req_wen;
      q_laddr[wr_idx] <= mem_req_addr[ADDR_W-1:OFFSET_W];
      q_wdata[wr_idx] <= mem_req_wdata;
    end
    if (load) begin
      eng_write <= ent_write;
      eng_laddr <= ent_laddr;
      eng_wdata <= ent_wdata;
    end
    if (eng_done && eng_write && !rst)
      mem[eng_line] <= eng_wdata;
  end

endmodule
